// File: rtl/router_pkg.sv
// Shared router types: flit type and direction encodings, flit field offsets and XY routing.
package router_pkg;

   typedef enum logic [1:0] {
      FT_SINGLE = 2'b00,
      FT_HEAD   = 2'b01,
      FT_BODY   = 2'b10,
      FT_TAIL   = 2'b11
   } flit_type_t;

   typedef enum logic [2:0] {
      DIR_LOCAL = 3'd0,
      DIR_NORTH = 3'd1,
      DIR_SOUTH = 3'd2,
      DIR_EAST  = 3'd3,
      DIR_WEST  = 3'd4
   } dir_t;

   localparam int TYPE_LSB  = 0;
   localparam int TYPE_W    = 2;
   localparam int DST_X_LSB = 2;   // dst_y follows dst_x immediately
   localparam int DIR_W     = 3;

   // X is resolved before Y. Coordinates are widened to 32 bits by the caller.
   function automatic dir_t route_xy(input logic [31:0] dst_x, input logic [31:0] my_x,
                                     input logic [31:0] dst_y, input logic [31:0] my_y);
      if (dst_x > my_x)      return DIR_EAST;
      else if (dst_x < my_x) return DIR_WEST;
      else if (dst_y > my_y) return DIR_NORTH;
      else if (dst_y < my_y) return DIR_SOUTH;
      else                   return DIR_LOCAL;
   endfunction

endpackage

// File: rtl/router_stage30_if.sv
// Flit handshake bundle: upstream input side and stage40-facing output side.
interface router_stage30_if #(parameter int FLIT_WIDTH = 64);
   logic [FLIT_WIDTH-1:0] in_flit;
   logic                  in_valid;
   logic                  in_ready;
   logic [FLIT_WIDTH-1:0] out_flit;
   logic [2:0]            out_dir;
   logic                  out_valid;
   logic                  out_ready;

   // Stage side
   modport slave (
      input  in_flit, in_valid, out_ready,
      output in_ready, out_flit, out_dir, out_valid
   );

   // Environment side (upstream producer + downstream consumer)
   modport master (
      output in_flit, in_valid, out_ready,
      input  in_ready, out_flit, out_dir, out_valid
   );
endinterface

// File: rtl/router_out_queue.sv
// Two-entry registered valid/ready FIFO. Head entry drives the output directly;
// in_ready depends only on occupancy so there is no ready path through the queue.
module router_out_queue #(
   parameter int DW = 67
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid_i,
   output logic          in_ready_o,
   input  logic [DW-1:0] in_data_i,
   output logic          out_valid_o,
   input  logic          out_ready_i,
   output logic [DW-1:0] out_data_o
);

   logic [1:0]    count_q, count_d;
   logic [DW-1:0] slot0_q, slot0_d, slot1_q, slot1_d;
   logic          push, pop;

   assign in_ready_o  = (count_q != 2'd2);
   assign out_valid_o = (count_q != 2'd0);
   assign out_data_o  = slot0_q;
   assign push        = in_valid_i && in_ready_o;
   assign pop         = out_valid_o && out_ready_i;

   // Occupancy and slot movement; slot0 is always the head
   always_comb begin
      count_d = count_q;
      slot0_d = slot0_q;
      slot1_d = slot1_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
      if (pop) begin
         if (count_q == 2'd2) slot0_d = slot1_q;
         else if (push)       slot0_d = in_data_i;
      end else if (push) begin
         if (count_q == 2'd0) slot0_d = in_data_i;
         else                 slot1_d = in_data_i;
      end
   end

   // Queue state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= 2'd0;
         slot0_q <= '0;
         slot1_q <= '0;
      end else begin
         count_q <= count_d;
         slot0_q <= slot0_d;
         slot1_q <= slot1_d;
      end
   end

endmodule

// File: rtl/router_stage30.sv
// Router stage 30: decodes flit type, computes XY route on SINGLE/HEAD, holds the
// direction for the rest of a packet, drops orphan BODY/TAIL flits and queues
// {dir, flit} toward stage40.
module router_stage30
   import router_pkg::*;
#(
   parameter int FLIT_WIDTH     = 64,
   parameter int COORD_WIDTH    = 4,
   parameter int DROP_CNT_WIDTH = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [COORD_WIDTH-1:0]    my_x,
   input  logic [COORD_WIDTH-1:0]    my_y,
   router_stage30_if.slave           bus,
   output logic                      busy,
   output logic                      proto_err,
   output logic [DROP_CNT_WIDTH-1:0] drop_count
);

   typedef enum logic {ST_IDLE, ST_IN_PACKET} state_t;

   state_t                    state_q, state_d;
   dir_t                      cur_dir_q, cur_dir_d, new_dir, enq_dir;
   logic                      perr_q, perr_d;
   logic [DROP_CNT_WIDTH-1:0] drop_q, drop_d;
   flit_type_t                ftype;
   logic [COORD_WIDTH-1:0]    dst_x, dst_y;
   logic                      is_route, drop, accept, q_in_ready;
   logic [DIR_W+FLIT_WIDTH-1:0] q_out;

   assign ftype    = flit_type_t'(bus.in_flit[TYPE_LSB +: TYPE_W]);
   assign dst_x    = bus.in_flit[DST_X_LSB +: COORD_WIDTH];
   assign dst_y    = bus.in_flit[DST_X_LSB + COORD_WIDTH +: COORD_WIDTH];
   assign new_dir  = route_xy(32'(dst_x), 32'(my_x), 32'(dst_y), 32'(my_y));
   assign is_route = (ftype == FT_SINGLE) || (ftype == FT_HEAD);
   // BODY/TAIL outside a packet is consumed but never enqueued
   assign drop     = (state_q == ST_IDLE) && !is_route;
   assign accept   = bus.in_valid && q_in_ready;
   assign enq_dir  = is_route ? new_dir : cur_dir_q;

   router_out_queue #(.DW(DIR_W + FLIT_WIDTH)) u_q (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid_i  (bus.in_valid && !drop),
      .in_ready_o  (q_in_ready),
      .in_data_i   ({enq_dir, bus.in_flit}),
      .out_valid_o (bus.out_valid),
      .out_ready_i (bus.out_ready),
      .out_data_o  (q_out)
   );

   assign bus.in_ready = q_in_ready;
   assign bus.out_flit = q_out[FLIT_WIDTH-1:0];
   assign bus.out_dir  = q_out[DIR_W+FLIT_WIDTH-1:FLIT_WIDTH];
   assign busy         = (state_q == ST_IN_PACKET);
   assign proto_err    = perr_q;
   assign drop_count   = drop_q;

   // Packet FSM, latched route, protocol error and drop counting on accepted flits
   always_comb begin
      state_d   = state_q;
      cur_dir_d = cur_dir_q;
      perr_d    = 1'b0;
      drop_d    = drop_q;
      if (accept) begin
         case (state_q)
            ST_IDLE: begin
               case (ftype)
                  FT_SINGLE: ;
                  FT_HEAD: begin
                     cur_dir_d = new_dir;
                     state_d   = ST_IN_PACKET;
                  end
                  default: begin
                     perr_d = 1'b1;
                     if (drop_q != '1) drop_d = drop_q + DROP_CNT_WIDTH'(1);
                  end
               endcase
            end
            default: begin
               case (ftype)
                  FT_BODY: ;
                  FT_TAIL: state_d = ST_IDLE;
                  FT_HEAD: begin
                     perr_d    = 1'b1;
                     cur_dir_d = new_dir;
                  end
                  default: begin
                     perr_d  = 1'b1;
                     state_d = ST_IDLE;
                  end
               endcase
            end
         endcase
      end
   end

   // Control state registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         cur_dir_q <= DIR_LOCAL;
         perr_q    <= 1'b0;
         drop_q    <= '0;
      end else begin
         state_q   <= state_d;
         cur_dir_q <= cur_dir_d;
         perr_q    <= perr_d;
         drop_q    <= drop_d;
      end
   end

endmodule

// File: tb/tb_router_stage30.sv
// Directed bench for router_stage30: routing, packet hold, backpressure, drops,
// protocol errors and asynchronous reset.
module tb_router_stage30;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [3:0] my_x = 4'd2, my_y = 4'd2;
   logic       busy, proto_err;
   logic [7:0] drop_count;
   int         tests = 0, fails = 0;

   router_stage30_if #(.FLIT_WIDTH(64)) bus();

   router_stage30 #(.FLIT_WIDTH(64), .COORD_WIDTH(4), .DROP_CNT_WIDTH(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .my_x       (my_x),
      .my_y       (my_y),
      .bus        (bus),
      .busy       (busy),
      .proto_err  (proto_err),
      .drop_count (drop_count)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] mk(input logic [1:0] t, input logic [3:0] dx,
                                      input logic [3:0] dy, input logic [31:0] tag);
      return {tag, 22'd0, dy, dx, t};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.in_valid  = 1'b0;
      bus.in_flit   = '0;
      bus.out_ready = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      #1;
   endtask

   task automatic test_reset();
      do_reset();
      tests++; if (bus.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", bus.in_ready); end
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); end
      tests++; if (busy !== 1'b0 || proto_err !== 1'b0) begin fails++; $display("FAIL reset_busy_perr got %b%b exp 00", busy, proto_err); end
      tests++; if (drop_count !== 8'd0) begin fails++; $display("FAIL reset_drop got %0d exp 0", drop_count); end
      tests++; if (bus.out_dir !== 3'd0 || bus.out_flit !== 64'd0) begin fails++; $display("FAIL reset_out got dir %0d flit %h exp 0", bus.out_dir, bus.out_flit); end
   endtask

   task automatic test_single();
      logic [63:0] f;
      do_reset();
      f = mk(2'b00, 4'd5, 4'd1, 32'hA5A5_0001);
      bus.out_ready = 1'b1;
      bus.in_flit = f; bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      tests++; if (bus.out_valid !== 1'b1) begin fails++; $display("FAIL single_valid got %b exp 1", bus.out_valid); end
      tests++; if (bus.out_dir !== 3'd3) begin fails++; $display("FAIL single_dir got %0d exp 3", bus.out_dir); end
      tests++; if (bus.out_flit !== f) begin fails++; $display("FAIL single_flit got %h exp %h", bus.out_flit, f); end
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL single_busy got %b exp 0", busy); end
      step();
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL single_drain got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [63:0] f [4];
      logic        eb [4];
      do_reset();
      f[0] = mk(2'b01, 4'd2, 4'd4, 32'h1000_0000); eb[0] = 1'b1;
      f[1] = mk(2'b10, 4'd9, 4'd9, 32'h1000_0001); eb[1] = 1'b1;
      f[2] = mk(2'b10, 4'd0, 4'd0, 32'h1000_0002); eb[2] = 1'b1;
      f[3] = mk(2'b11, 4'd7, 4'd0, 32'h1000_0003); eb[3] = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         bus.in_flit = f[i]; bus.in_valid = 1'b1;
         step();
         tests++; if (bus.out_valid !== 1'b1 || bus.out_flit !== f[i]) begin fails++; $display("FAIL b2b_flit%0d got v%b %h exp v1 %h", i, bus.out_valid, bus.out_flit, f[i]); end
         tests++; if (bus.out_dir !== 3'd1) begin fails++; $display("FAIL b2b_dir%0d got %0d exp 1", i, bus.out_dir); end
         tests++; if (busy !== eb[i]) begin fails++; $display("FAIL b2b_busy%0d got %b exp %b", i, busy, eb[i]); end
      end
      bus.in_valid = 1'b0;
      step();
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_backpressure();
      logic [63:0] a, b, c;
      do_reset();
      a = mk(2'b00, 4'd5, 4'd1, 32'hB000_000A);  // EAST
      b = mk(2'b00, 4'd0, 4'd0, 32'hB000_000B);  // WEST
      c = mk(2'b00, 4'd2, 4'd2, 32'hB000_000C);  // LOCAL
      bus.out_ready = 1'b0;
      bus.in_flit = a; bus.in_valid = 1'b1; step();
      bus.in_flit = b; step();
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_full got in_ready %b exp 0", bus.in_ready); end
      bus.in_flit = c; step();
      tests++; if (bus.in_ready !== 1'b0 || bus.out_flit !== a || bus.out_dir !== 3'd3) begin fails++; $display("FAIL bp_hold got rdy %b %h dir %0d exp 0 %h 3", bus.in_ready, bus.out_flit, bus.out_dir, a); end
      bus.out_ready = 1'b1;
      #1;
      tests++; if (bus.in_ready !== 1'b0) begin fails++; $display("FAIL bp_no_comb got in_ready %b exp 0", bus.in_ready); end
      step();
      tests++; if (bus.out_flit !== b || bus.out_dir !== 3'd4 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL bp_b got %h dir %0d rdy %b exp %h 4 1", bus.out_flit, bus.out_dir, bus.in_ready, b); end
      step();
      bus.in_valid = 1'b0;
      tests++; if (bus.out_valid !== 1'b1 || bus.out_flit !== c || bus.out_dir !== 3'd0) begin fails++; $display("FAIL bp_c got v%b %h dir %0d exp v1 %h 0", bus.out_valid, bus.out_flit, bus.out_dir, c); end
      step();
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_drop();
      do_reset();
      bus.out_ready = 1'b1;
      bus.in_flit = mk(2'b10, 4'd1, 4'd1, 32'hD0); bus.in_valid = 1'b1;
      step();
      tests++; if (proto_err !== 1'b1 || bus.out_valid !== 1'b0 || drop_count !== 8'd1) begin fails++; $display("FAIL drop_body got perr %b v %b cnt %0d exp 1 0 1", proto_err, bus.out_valid, drop_count); end
      bus.in_flit = mk(2'b11, 4'd1, 4'd1, 32'hD1);
      step();
      bus.in_valid = 1'b0;
      tests++; if (proto_err !== 1'b1 || bus.out_valid !== 1'b0 || drop_count !== 8'd2) begin fails++; $display("FAIL drop_tail got perr %b v %b cnt %0d exp 1 0 2", proto_err, bus.out_valid, drop_count); end
      step();
      tests++; if (proto_err !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL drop_pulse got perr %b busy %b exp 0 0", proto_err, busy); end
      bus.in_flit = mk(2'b10, 4'd0, 4'd0, 32'hD2); bus.in_valid = 1'b1;
      repeat (300) @(posedge clk);
      #1 bus.in_valid = 1'b0;
      tests++; if (drop_count !== 8'd255) begin fails++; $display("FAIL drop_sat got %0d exp 255", drop_count); end
      tests++; if (bus.out_valid !== 1'b0) begin fails++; $display("FAIL drop_noenq got %b exp 0", bus.out_valid); end
   endtask

   task automatic test_head_head();
      do_reset();
      bus.out_ready = 1'b1;
      bus.in_flit = mk(2'b01, 4'd0, 4'd2, 32'hE0); bus.in_valid = 1'b1;
      step();
      tests++; if (bus.out_dir !== 3'd4 || busy !== 1'b1 || proto_err !== 1'b0) begin fails++; $display("FAIL hh_first got dir %0d busy %b perr %b exp 4 1 0", bus.out_dir, busy, proto_err); end
      bus.in_flit = mk(2'b01, 4'd2, 4'd2, 32'hE1);
      step();
      bus.in_valid = 1'b0;
      tests++; if (bus.out_dir !== 3'd0 || busy !== 1'b1 || proto_err !== 1'b1) begin fails++; $display("FAIL hh_second got dir %0d busy %b perr %b exp 0 1 1", bus.out_dir, busy, proto_err); end
      step();
      tests++; if (proto_err !== 1'b0 || busy !== 1'b1) begin fails++; $display("FAIL hh_after got perr %b busy %b exp 0 1", proto_err, busy); end
   endtask

   task automatic test_async_reset();
      do_reset();
      bus.out_ready = 1'b0;
      bus.in_flit = mk(2'b11, 4'd0, 4'd0, 32'hF0); bus.in_valid = 1'b1; step();
      bus.in_flit = mk(2'b01, 4'd5, 4'd2, 32'hF1); step();
      bus.in_flit = mk(2'b10, 4'd0, 4'd0, 32'hF2); step();
      bus.in_valid = 1'b0;
      tests++; if (bus.out_valid !== 1'b1 || busy !== 1'b1 || drop_count !== 8'd1) begin fails++; $display("FAIL ar_pre got v %b busy %b cnt %0d exp 1 1 1", bus.out_valid, busy, drop_count); end
      #2 rst_n = 1'b0;
      #1;
      tests++; if (bus.out_valid !== 1'b0 || busy !== 1'b0 || drop_count !== 8'd0 || bus.in_ready !== 1'b1) begin fails++; $display("FAIL ar_now got v %b busy %b cnt %0d rdy %b exp 0 0 0 1", bus.out_valid, busy, drop_count, bus.in_ready); end
      #2 rst_n = 1'b1;
      @(negedge clk);
      bus.in_flit = mk(2'b10, 4'd3, 4'd3, 32'hF3); bus.in_valid = 1'b1;
      step();
      bus.in_valid = 1'b0;
      tests++; if (drop_count !== 8'd1 || bus.out_valid !== 1'b0 || proto_err !== 1'b1 || busy !== 1'b0) begin fails++; $display("FAIL ar_body got cnt %0d v %b perr %b busy %b exp 1 0 1 0", drop_count, bus.out_valid, proto_err, busy); end
   endtask

   initial begin
      bus.in_flit = '0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_drop();
      test_head_head();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
